// File: rtl/uart_loopback_buffer_pkg.sv
// Shared types and constants for the uart_rx -> uart_tx loopback buffer.
// The sequencer encoding is fixed so state values stay comparable with the older netlists.
package uart_loopback_buffer_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/uart_loopback_buffer_sync_fifo.sv
// Circular byte FIFO with a separate occupancy counter.
// A push and a pop may both occur in the same cycle.
module sync_fifo
    import uart_loopback_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [BYTE_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [BYTE_W-1:0] rdata_o,
    output logic [AW:0]       count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              wr_en, rd_en;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Fullness is judged on the pre-edge count, so a push into a full FIFO drops even alongside a pop.
    always_comb begin
        wr_en    = push_i && !full_o;
        rd_en    = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_loopback_buffer.sv
// Captures bytes from uart_rx on the rising edge of rx_ready, buffers them, and replays
// them in order to uart_tx through a start/busy handshake; dropped bytes set a sticky flag.
module uart_loopback_buffer
    import uart_loopback_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              bclk,
    input  logic              rst,
    input  logic              rx_ready,
    input  logic [BYTE_W-1:0] rx_dout,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_din,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    seq_state_e        state_q, state_d;
    logic              rx_ready_q;
    logic              overflow_q;
    logic [BYTE_W-1:0] tx_din_q;
    logic              push;
    logic              pop;
    logic [BYTE_W-1:0] head_byte;

    // A level held for many cycles yields a single push.
    assign push = rx_ready && !rx_ready_q;

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i   (bclk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (rx_dout),
        .pop_i   (pop),
        .rdata_o (head_byte),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        tx_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                tx_start = 1'b1;
                state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge bclk) begin
        if (rst) begin
            state_q    <= IDLE;
            rx_ready_q <= 1'b0;
            overflow_q <= 1'b0;
            tx_din_q   <= '0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready;
            if (push && full) begin
                overflow_q <= 1'b1;
            end
            if (pop) begin
                tx_din_q <= head_byte;
            end
        end
    end

    assign tx_din   = tx_din_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_loopback_buffer.sv
// Scoreboard bench: a transaction-level reference model predicts transmitted bytes and flags.
module tb_uart_loopback_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic       bclk;
    logic       rst;
    logic       rx_ready;
    logic [7:0] rx_dout;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_din;
    logic [AW:0] count;
    logic       full;
    logic       empty;
    logic       overflow;

    logic        force_busy;
    logic        model_busy;
    int unsigned busy_len;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;

    assign tx_busy = force_busy | model_busy;

    uart_loopback_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .bclk     (bclk),
        .rst      (rst),
        .rx_ready (rx_ready),
        .rx_dout  (rx_dout),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_din   (tx_din),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    initial begin
        bclk = 1'b0;
        forever #5 bclk = ~bclk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of buffered bytes plus a "frame in flight" notion.
    byte unsigned m_fifo[$];
    byte unsigned exp_tx[$];
    bit           m_valid = 0;
    bit           m_ovf, m_rx_prev, m_active, m_acked, m_start_now;
    int           m_age;
    byte unsigned m_cur;
    bit           do_pop, do_push, was_full;

    always @(posedge bclk) begin
        if (rst) begin
            m_fifo.delete();
            exp_tx.delete();
            m_ovf = 0; m_rx_prev = 0; m_active = 0; m_acked = 0;
            m_age = 0; m_cur = 0; m_start_now = 0; m_valid = 1;
        end else begin
            was_full = (m_fifo.size() == DEPTH);
            do_pop   = !m_active && (m_fifo.size() != 0);
            do_push  = rx_ready && !m_rx_prev;
            if (do_push && was_full) m_ovf = 1;
            m_start_now = 0;
            if (m_active) begin
                m_age++;
                if (!m_acked) begin
                    if (m_age >= 2 && tx_busy) m_acked = 1;
                end else if (!tx_busy) begin
                    m_active = 0;
                end
            end
            if (do_pop) begin
                m_cur = m_fifo.pop_front();
                exp_tx.push_back(m_cur);
                m_active = 1; m_acked = 0; m_age = 0; m_start_now = 1;
            end
            if (do_push && !was_full) m_fifo.push_back(rx_dout);
            m_rx_prev = rx_ready;
        end
    end

    // Flag and timing checks against the model.
    always @(negedge bclk) begin
        if (m_valid) begin
            chk("count", 32'(count), 32'(m_fifo.size()));
            chk("full", 32'(full), 32'(m_fifo.size() == DEPTH));
            chk("empty", 32'(empty), 32'(m_fifo.size() == 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("tx_start", 32'(tx_start), 32'(m_start_now));
            chk("tx_din_hold", 32'(tx_din), 32'(m_cur));
        end
    end

    // Scoreboard monitor: each tx_start consumes the next expected byte.
    always @(negedge bclk) begin
        if (m_valid && tx_start === 1'b1) begin
            start_cnt++;
            if (exp_tx.size() == 0) begin
                chk("unexpected_start", 32'(tx_din), 32'hFFFF_FFFF);
            end else begin
                chk("tx_byte", 32'(tx_din), 32'(exp_tx.pop_front()));
            end
        end
    end

    // uart_tx stand-in: busy for busy_len cycles after each start.
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge bclk);
            if (tx_start === 1'b1) begin
                @(posedge bclk); #1;
                model_busy = 1'b1;
                repeat (busy_len) @(posedge bclk);
                #1;
                model_busy = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge bclk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int hold, input int gap);
        rx_ready = 1'b1;
        rx_dout  = b;
        tick(hold);
        rx_ready = 1'b0;
        rx_dout  = 8'($urandom);
        tick(gap);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((m_fifo.size() != 0 || m_active || exp_tx.size() != 0) && n < 3000) begin
            tick(1);
            n++;
        end
        chk("drain_done", 32'(n < 3000), 32'd1);
    endtask

    int snap;

    initial begin
        rst = 1'b1; rx_ready = 1'b0; rx_dout = '0;
        force_busy = 1'b0; busy_len = 20;
        tick(3);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_din", 32'(tx_din), 32'd0);
        rst = 1'b0;
        tick(2);

        // single byte
        snap = start_cnt;
        send(8'hA5, 1, 0);
        chk("single_count", 32'(count), 32'd1);
        tick(30);
        chk("single_starts", 32'(start_cnt - snap), 32'd1);
        chk("single_drained", 32'(count), 32'd0);

        // held level
        snap = start_cnt;
        send(8'h3C, 50, 5);
        tick(30);
        chk("held_starts", 32'(start_cnt - snap), 32'd1);

        // burst ordering under held busy
        force_busy = 1'b1;
        busy_len = 10;
        for (int i = 1; i <= 5; i++) send(8'(i), 1, 1);
        chk("burst_peak", 32'(count), 32'd4);
        force_busy = 1'b0;
        wait_drain();

        // overflow and pointer wrap
        force_busy = 1'b1;
        send(8'hEE, 1, 1);
        for (int i = 0; i <= 16; i++) send(8'(8'h10 + i), 1, 1);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'(DEPTH));
        force_busy = 1'b0;
        wait_drain();
        send(8'h55, 1, 1);
        wait_drain();

        // push on the exact pop edge
        busy_len = 2;
        force_busy = 1'b1;
        send(8'hA1, 1, 1);
        send(8'hB2, 1, 1);
        tick(6);
        force_busy = 1'b0;
        tick(1);
        rx_ready = 1'b1;
        rx_dout  = 8'hC3;
        tick(1);
        rx_ready = 1'b0;
        chk("push_pop_count", 32'(count), 32'd1);
        wait_drain();

        // reset mid-frame
        busy_len = 5;
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) send(8'(8'hD0 + i), 1, 1);
        tick(3);
        chk("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_tx_start", 32'(tx_start), 32'd0);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        snap = start_cnt;
        tick(10);
        force_busy = 1'b0;
        tick(20);
        chk("midrst_no_start", 32'(start_cnt - snap), 32'd0);
        send(8'h77, 1, 1);
        wait_drain();

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            busy_len = $urandom_range(1, 12);
            if ($urandom_range(0, 9) == 0) force_busy = ~force_busy;
            send(8'($urandom), $urandom_range(1, 4), $urandom_range(1, 6));
        end
        force_busy = 1'b0;
        wait_drain();

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
